// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and constants for the pipeline stage register:
//                occupancy-encoded state values and the NOP control word.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    // Skid state is encoded directly as the number of held entries, so the
    // state register doubles as the occupancy output.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Widest control bundle supported; users slice the low CTRL_W bits.
    localparam int C_MAX_CTRL_W = 64;

    // All-zero control word: a bubble presented downstream behaves as a NOP.
    localparam logic [C_MAX_CTRL_W-1:0] C_NOP_CTRL = '0;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_if
//  Description : Handshake bundle around one pipeline stage boundary. The
//                slave modport is the stage itself; master is the environment
//                (upstream producer, downstream consumer and flush source).
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_stage_if #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 9
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;

    modport slave (
        input  in_valid, in_data, in_ctrl, flush, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, occupancy
    );

    modport master (
        output in_valid, in_data, in_ctrl, flush, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, occupancy
    );
endinterface : pipe_stage_if
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_slot
//  Description : One pipeline entry: valid, data and control registers with
//                load and clear. Clear wins over load and zeroes everything,
//                so an empty slot always holds a NOP.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 9
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              load,
    input  wire logic              clear,
    input  wire logic [DATA_W-1:0] d_data,
    input  wire logic [CTRL_W-1:0] d_ctrl,
    output logic                   valid,
    output logic      [DATA_W-1:0] data,
    output logic      [CTRL_W-1:0] ctrl
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    // Entry register: clear has priority so flush/drain leaves a clean NOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= C_NOP_CTRL[CTRL_W-1:0];
        end else if (clear) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= C_NOP_CTRL[CTRL_W-1:0];
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= d_data;
            r_ctrl  <= d_ctrl;
        end
    end

    assign valid = r_valid;
    assign data  = r_data;
    assign ctrl  = r_ctrl;

endmodule : pipe_slot
`default_nettype wire

// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage
//  Description : Pipeline stage register with valid/ready back-pressure and
//                flush. SKID=1 holds up to two entries and drives in_ready
//                purely from the state register; SKID=0 holds one entry and
//                drives in_ready combinationally from out_ready.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 9,
    parameter int SKID   = 1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    pipe_stage_if.slave bus
);

    logic              w_in_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_head_load;
    logic              w_head_clear;
    logic [DATA_W-1:0] w_head_d_data;
    logic [CTRL_W-1:0] w_head_d_ctrl;
    logic              w_head_valid;
    logic [DATA_W-1:0] w_head_data;
    logic [CTRL_W-1:0] w_head_ctrl;
    logic [1:0]        w_occupancy;

    // An input offered during flush is never accepted.
    assign w_push = bus.in_valid & w_in_ready & ~bus.flush;
    assign w_pop  = w_head_valid & bus.out_ready;

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_head (
        .clk    (clk),
        .rst    (rst),
        .load   (w_head_load),
        .clear  (w_head_clear),
        .d_data (w_head_d_data),
        .d_ctrl (w_head_d_ctrl),
        .valid  (w_head_valid),
        .data   (w_head_data),
        .ctrl   (w_head_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            state_t            r_state;
            state_t            w_state_nxt;
            logic              w_head_sel_skid;
            logic              w_skid_load;
            logic              w_skid_clear;
            logic              w_skid_valid;
            logic [DATA_W-1:0] w_skid_data;
            logic [CTRL_W-1:0] w_skid_ctrl;

            pipe_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk    (clk),
                .rst    (rst),
                .load   (w_skid_load),
                .clear  (w_skid_clear),
                .d_data (bus.in_data),
                .d_ctrl (bus.in_ctrl),
                .valid  (w_skid_valid),
                .data   (w_skid_data),
                .ctrl   (w_skid_ctrl)
            );

            // State register; its value is also the occupancy count.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state <= ST_EMPTY;
                end else begin
                    r_state <= w_state_nxt;
                end
            end

            // Next state and slot control. The head always holds the oldest
            // entry; the skid only catches the one push that lands while the
            // head is stalled, and refills the head when that drains.
            always_comb begin
                w_state_nxt     = r_state;
                w_head_load     = 1'b0;
                w_head_clear    = 1'b0;
                w_head_sel_skid = 1'b0;
                w_skid_load     = 1'b0;
                w_skid_clear    = 1'b0;
                if (bus.flush) begin
                    w_state_nxt  = ST_EMPTY;
                    w_head_clear = 1'b1;
                    w_skid_clear = 1'b1;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_push) begin
                                w_head_load = 1'b1;
                                w_state_nxt = ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (w_push && !w_pop) begin
                                w_skid_load = 1'b1;
                                w_state_nxt = ST_TWO;
                            end else if (w_push && w_pop) begin
                                w_head_load = 1'b1;
                            end else if (w_pop) begin
                                w_head_clear = 1'b1;
                                w_state_nxt  = ST_EMPTY;
                            end
                        end
                        ST_TWO: begin
                            if (w_pop && w_skid_valid) begin
                                w_head_load     = 1'b1;
                                w_head_sel_skid = 1'b1;
                                w_skid_clear    = 1'b1;
                                w_state_nxt     = ST_ONE;
                            end
                        end
                        default: begin
                            w_state_nxt  = ST_EMPTY;
                            w_head_clear = 1'b1;
                            w_skid_clear = 1'b1;
                        end
                    endcase
                end
            end

            // Head load source: the waiting skid entry, else the upstream bus.
            assign w_head_d_data = w_head_sel_skid ? w_skid_data : bus.in_data;
            assign w_head_d_ctrl = w_head_sel_skid ? w_skid_ctrl : bus.in_ctrl;

            // Registered ready: stalls never ripple combinationally upstream.
            assign w_in_ready  = (r_state != ST_TWO);
            assign w_occupancy = r_state;
        end else begin : g_single
            // Single entry: load on push, drop to empty on pop without push.
            always_comb begin
                w_head_load  = w_push;
                w_head_clear = bus.flush | (w_pop & ~w_push);
            end

            assign w_head_d_data = bus.in_data;
            assign w_head_d_ctrl = bus.in_ctrl;

            assign w_in_ready  = ~w_head_valid | bus.out_ready;
            assign w_occupancy = {1'b0, w_head_valid};
        end
    endgenerate

    // Outputs come only from registers; an empty stage presents a NOP.
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_head_valid;
    assign bus.out_data  = w_head_valid ? w_head_data : '0;
    assign bus.out_ctrl  = w_head_valid ? w_head_ctrl : C_NOP_CTRL[CTRL_W-1:0];
    assign bus.occupancy = w_occupancy;

endmodule : pipe_stage
`default_nettype wire

// File: tb/tb_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage
//  Description : Bench for pipe_stage. A SKID=1 and a SKID=0 instance share
//                the same stimulus; each is compared every cycle against a
//                queue model of an in-order buffer of capacity 2 or 1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stage;

    localparam int DATA_W = 16;
    localparam int CTRL_W = 9;

    logic clk;
    logic rst;

    logic              tb_in_valid;
    logic [DATA_W-1:0] tb_in_data;
    logic [CTRL_W-1:0] tb_in_ctrl;
    logic              tb_flush;
    logic              tb_out_ready;

    int checks;
    int errors;

    // Reference queues: each element is {ctrl, data}, head at index 0.
    logic [CTRL_W+DATA_W-1:0] q1[$];
    logic [CTRL_W+DATA_W-1:0] q0[$];

    pipe_stage_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus1 ();
    pipe_stage_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus0 ();

    assign bus1.in_valid  = tb_in_valid;
    assign bus1.in_data   = tb_in_data;
    assign bus1.in_ctrl   = tb_in_ctrl;
    assign bus1.flush     = tb_flush;
    assign bus1.out_ready = tb_out_ready;
    assign bus0.in_valid  = tb_in_valid;
    assign bus0.in_data   = tb_in_data;
    assign bus0.in_ctrl   = tb_in_ctrl;
    assign bus0.flush     = tb_flush;
    assign bus0.out_ready = tb_out_ready;

    pipe_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    pipe_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic r);
        tb_in_valid  = v;
        tb_in_data   = d;
        tb_in_ctrl   = {1'b1, d[7:0]};
        tb_out_ready = r;
    endtask

    // Compare one instance against what an in-order buffer of the given
    // capacity must show: head entry or a NOP bubble, and its fill level.
    task automatic cmp_model(input string tag, input int cap, input int size,
                             input logic [CTRL_W+DATA_W-1:0] head,
                             input logic rdy, input logic vld,
                             input logic [DATA_W-1:0] dat,
                             input logic [CTRL_W-1:0] ctl, input logic [1:0] occ);
        logic exp_rdy;
        exp_rdy = (cap == 2) ? (size < 2) : (size == 0 || tb_out_ready);
        chk({tag, ".in_ready"},  32'(rdy), 32'(exp_rdy));
        chk({tag, ".out_valid"}, 32'(vld), 32'(size > 0));
        chk({tag, ".out_data"},  32'(dat), (size > 0) ? 32'(head[DATA_W-1:0]) : 32'd0);
        chk({tag, ".out_ctrl"},  32'(ctl), (size > 0) ? 32'(head[CTRL_W+DATA_W-1:DATA_W]) : 32'd0);
        chk({tag, ".occupancy"}, 32'(occ), 32'(size));
    endtask

    // One clock: check both instances mid-cycle, then advance both models
    // with the transfers that happen at the rising edge.
    task automatic tick();
        logic pop1, pop0, push1, push0;
        logic [CTRL_W+DATA_W-1:0] h1, h0;
        @(negedge clk);
        h1 = (q1.size() > 0) ? q1[0] : '0;
        h0 = (q0.size() > 0) ? q0[0] : '0;
        cmp_model("skid1", 2, q1.size(), h1, bus1.in_ready, bus1.out_valid,
                  bus1.out_data, bus1.out_ctrl, bus1.occupancy);
        cmp_model("skid0", 1, q0.size(), h0, bus0.in_ready, bus0.out_valid,
                  bus0.out_data, bus0.out_ctrl, bus0.occupancy);
        pop1  = (q1.size() > 0) && tb_out_ready;
        pop0  = (q0.size() > 0) && tb_out_ready;
        push1 = tb_in_valid && !tb_flush && (q1.size() < 2);
        push0 = tb_in_valid && !tb_flush && (q0.size() == 0 || tb_out_ready);
        @(posedge clk);
        if (pop1) void'(q1.pop_front());
        if (pop0) void'(q0.pop_front());
        if (tb_flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (push1) q1.push_back({tb_in_ctrl, tb_in_data});
            if (push0) q0.push_back({tb_in_ctrl, tb_in_data});
        end
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk    = 1'b0;
        rst    = 1'b1;
        tb_flush = 1'b0;
        drive(1'b0, 16'h0000, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset values.
        chk("rst.out_valid", 32'(bus1.out_valid), 32'd0);
        chk("rst.out_data",  32'(bus1.out_data),  32'd0);
        chk("rst.out_ctrl",  32'(bus1.out_ctrl),  32'd0);
        chk("rst.occupancy", 32'(bus1.occupancy), 32'd0);
        chk("rst.in_ready1", 32'(bus1.in_ready),  32'd1);
        chk("rst.in_ready0", 32'(bus0.in_ready),  32'd1);

        // Streaming with out_ready held high: one per cycle, one-cycle latency.
        drive(1'b1, 16'h1111, 1'b1);
        tick();
        chk("stream.first_data", 32'(bus1.out_data), 32'h1111);
        drive(1'b1, 16'h2222, 1'b1);
        tick();
        chk("stream.second_data", 32'(bus1.out_data), 32'h2222);
        drive(1'b1, 16'h3333, 1'b1);
        tick();
        chk("stream.occupancy", 32'(bus1.occupancy), 32'd1);
        chk("stream.in_ready",  32'(bus1.in_ready),  32'd1);
        drive(1'b0, 16'h0000, 1'b1);
        tick();

        // Back-pressure: AAAA stalls at head, BBBB lands in the skid.
        drive(1'b1, 16'hAAAA, 1'b1);
        tick();
        drive(1'b1, 16'hBBBB, 1'b0);
        tick();
        chk("bp.in_ready",  32'(bus1.in_ready),  32'd0);
        chk("bp.occupancy", 32'(bus1.occupancy), 32'd2);
        drive(1'b0, 16'h0000, 1'b1);
        tick();
        chk("bp.drain_head", 32'(bus1.out_data), 32'hBBBB);
        tick();
        tick();

        // Flush while full with a valid input offered in the same cycle.
        drive(1'b1, 16'h1234, 1'b0);
        tick();
        drive(1'b1, 16'h4321, 1'b0);
        tick();
        chk("fl.full", 32'(bus1.occupancy), 32'd2);
        drive(1'b1, 16'hCCCC, 1'b0);
        tb_flush = 1'b1;
        tick();
        tb_flush = 1'b0;
        drive(1'b0, 16'h0000, 1'b1);
        chk("fl.out_valid", 32'(bus1.out_valid), 32'd0);
        chk("fl.out_ctrl",  32'(bus1.out_ctrl),  32'd0);
        chk("fl.occupancy", 32'(bus1.occupancy), 32'd0);
        chk("fl.in_ready",  32'(bus1.in_ready),  32'd1);
        tick();
        tick();

        // Single-entry mode: ready follows out_ready combinationally.
        drive(1'b1, 16'h7777, 1'b0);
        tick();
        drive(1'b1, 16'h8888, 1'b0);
        #1;
        chk("s0.stalled_ready", 32'(bus0.in_ready), 32'd0);
        tb_out_ready = 1'b1;
        #1;
        chk("s0.comb_ready", 32'(bus0.in_ready), 32'd1);
        tick();
        chk("s0.push_pop_data", 32'(bus0.out_data),  32'h8888);
        chk("s0.push_pop_occ",  32'(bus0.occupancy), 32'd1);
        drive(1'b0, 16'h0000, 1'b1);
        tick();
        tick();

        // Asynchronous reset between edges while the skid instance is full.
        drive(1'b1, 16'h9999, 1'b0);
        tick();
        drive(1'b1, 16'hAAA1, 1'b0);
        tick();
        chk("ar.full", 32'(bus1.occupancy), 32'd2);
        #1 rst = 1'b1;
        #1;
        chk("ar.out_valid", 32'(bus1.out_valid), 32'd0);
        chk("ar.out_data",  32'(bus1.out_data),  32'd0);
        chk("ar.out_ctrl",  32'(bus1.out_ctrl),  32'd0);
        chk("ar.occupancy", 32'(bus1.occupancy), 32'd0);
        chk("ar.in_ready",  32'(bus1.in_ready),  32'd1);
        chk("ar.out_valid0", 32'(bus0.out_valid), 32'd0);
        q1.delete();
        q0.delete();
        rst = 1'b0;
        drive(1'b1, 16'h5A5A, 1'b1);
        tick();
        drive(1'b0, 16'h0000, 1'b1);
        chk("ar.first1", 32'(bus1.out_data), 32'h5A5A);
        chk("ar.first0", 32'(bus0.out_data), 32'h5A5A);
        tick();

        // Randomised valid/ready/flush against the reference queues.
        for (int i = 0; i < 400; i++) begin
            tb_in_valid  = ($urandom_range(0, 3) != 0);
            tb_in_data   = DATA_W'($urandom);
            tb_in_ctrl   = CTRL_W'($urandom);
            tb_out_ready = ($urandom_range(0, 2) != 0);
            tb_flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        tb_flush = 1'b0;
        drive(1'b0, 16'h0000, 1'b1);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipe_stage
`default_nettype wire
